// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - load-use/jump/memory-wait hazard controller for the 5-stage pipeline
module hazard_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_r2,
    input  logic [3:0]       id_r3,
    input  logic             id_uses_r2,
    input  logic             id_uses_r3,
    input  logic [3:0]       ex_dest,
    input  logic             ex_rmem,
    input  logic             ex_wreg,
    input  logic             jump_en,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    // Remaining stall cycles after the detection cycle (detection cycle itself is not counted here)
    localparam logic [2:0]       L_REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_CNT_MAX  = '1;

    state_t           r_state;
    state_t           r_ret;
    logic [2:0]       r_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    state_t           w_nxt_state;
    state_t           w_nxt_ret;
    state_t           w_eff;
    logic [2:0]       w_nxt_rem;
    logic             w_hz;
    logic             w_flush;

    assign w_hz = ex_rmem & ex_wreg &
                  ((id_uses_r2 & (id_r2 == ex_dest)) | (id_uses_r3 & (id_r3 == ex_dest)));

    // When a memory wait ends, this cycle behaves as the state that was interrupted
    assign w_eff = (r_state == S_MEMWAIT) ? r_ret : r_state;

    // State, remaining-cycle and return-state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_ret   <= S_RUN;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_nxt_state;
            r_ret   <= w_nxt_ret;
            r_rem   <= w_nxt_rem;
        end
    end

    // Next-state and control outputs; priority mem_busy > jump_en > hazard
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_ret    = r_ret;
        w_nxt_rem    = r_rem;
        w_flush      = 1'b0;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;

        if (mem_busy) begin
            // Freeze everything upstream of memory and drain a bubble into writeback
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
            w_nxt_state  = S_MEMWAIT;
            if (r_state != S_MEMWAIT) begin
                w_nxt_ret = r_state;
            end
        end else begin
            case (w_eff)
                S_LDSTALL: begin
                    if (jump_en) begin
                        // Cannot happen with a bubble in execute; recover as a plain jump flush
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        w_flush     = 1'b1;
                        w_nxt_rem   = 3'd0;
                        w_nxt_state = S_RUN;
                    end else begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        w_nxt_rem   = r_rem - 3'd1;
                        w_nxt_state = (r_rem <= 3'd1) ? S_RUN : S_LDSTALL;
                    end
                end
                default: begin
                    w_nxt_state = S_RUN;
                    if (jump_en) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        w_flush     = 1'b1;
                    end else if (w_hz) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_nxt_rem   = L_REM_INIT;
                            w_nxt_state = S_LDSTALL;
                        end
                    end
                end
            endcase
        end
    end

    // Saturating performance counters; clear beats increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_hold && (r_stall_cnt != L_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != L_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_r2, id_r3, ex_dest;
    logic       id_uses_r2, id_uses_r3, ex_rmem, ex_wreg, jump_en, mem_busy, clr_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance A: N=1, 16-bit counters
    logic        a_pc, a_ifh, a_iff, a_idh, a_idb, a_exh, a_mwb;
    logic [15:0] a_sc, a_fc;
    logic [1:0]  a_st;
    // Instance B: N=3, 16-bit counters
    logic        b_pc, b_ifh, b_iff, b_idh, b_idb, b_exh, b_mwb;
    logic [15:0] b_sc, b_fc;
    logic [1:0]  b_st;
    // Instance C: N=1, 4-bit counters
    logic        c_pc, c_ifh, c_iff, c_idh, c_idb, c_exh, c_mwb;
    logic [3:0]  c_sc, c_fc;
    logic [1:0]  c_st;

    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_r2(id_r2), .id_r3(id_r3), .id_uses_r2(id_uses_r2),
        .id_uses_r3(id_uses_r3), .ex_dest(ex_dest), .ex_rmem(ex_rmem), .ex_wreg(ex_wreg),
        .jump_en(jump_en), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_hold(a_pc), .ifid_hold(a_ifh), .ifid_flush(a_iff), .idex_hold(a_idh),
        .idex_bubble(a_idb), .exmem_hold(a_exh), .memwb_bubble(a_mwb),
        .stall_cnt(a_sc), .flush_cnt(a_fc), .state(a_st));

    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_r2(id_r2), .id_r3(id_r3), .id_uses_r2(id_uses_r2),
        .id_uses_r3(id_uses_r3), .ex_dest(ex_dest), .ex_rmem(ex_rmem), .ex_wreg(ex_wreg),
        .jump_en(jump_en), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_hold(b_pc), .ifid_hold(b_ifh), .ifid_flush(b_iff), .idex_hold(b_idh),
        .idex_bubble(b_idb), .exmem_hold(b_exh), .memwb_bubble(b_mwb),
        .stall_cnt(b_sc), .flush_cnt(b_fc), .state(b_st));

    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .id_r2(id_r2), .id_r3(id_r3), .id_uses_r2(id_uses_r2),
        .id_uses_r3(id_uses_r3), .ex_dest(ex_dest), .ex_rmem(ex_rmem), .ex_wreg(ex_wreg),
        .jump_en(jump_en), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
        .pc_hold(c_pc), .ifid_hold(c_ifh), .ifid_flush(c_iff), .idex_hold(c_idh),
        .idex_bubble(c_idb), .exmem_hold(c_exh), .memwb_bubble(c_mwb),
        .stall_cnt(c_sc), .flush_cnt(c_fc), .state(c_st));

    task automatic zero_inputs();
        id_r2 = 4'd0; id_r3 = 4'd0; ex_dest = 4'd0;
        id_uses_r2 = 1'b0; id_uses_r3 = 1'b0; ex_rmem = 1'b0; ex_wreg = 1'b0;
        jump_en = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_vec();
        ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd5; id_r2 = 4'd5; id_uses_r2 = 1'b1;
    endtask

    task automatic settle_and_clear();
        zero_inputs();
        repeat (4) next_cycle();
        clr_cnt = 1'b1;
        next_cycle();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifh, a_iff, a_idh, a_idb, a_exh, a_mwb} !== 7'b0) begin
            failures++; $display("FAIL reset_outputs got=%b want=0000000", {a_pc, a_ifh, a_iff, a_idh, a_idb, a_exh, a_mwb});
        end
        checks++;
        if (a_st !== 2'd0 || a_sc !== 16'd0 || a_fc !== 16'd0) begin
            failures++; $display("FAIL reset_regs state=%0d stall=%0d flush=%0d want 0/0/0", a_st, a_sc, a_fc);
        end
        next_cycle();
    endtask

    task automatic test_hazard_decode();
        logic [8:0] vec [6];
        logic       want [6];
        // {ex_rmem, ex_wreg, uses_r2, uses_r3, r2_eq, r3_eq, ...padding}
        vec[0] = 9'b11_10_10_000; want[0] = 1'b1;
        vec[1] = 9'b11_01_01_000; want[1] = 1'b1;
        vec[2] = 9'b11_01_10_000; want[2] = 1'b0;
        vec[3] = 9'b10_10_10_000; want[3] = 1'b0;
        vec[4] = 9'b01_10_10_000; want[4] = 1'b0;
        vec[5] = 9'b11_00_11_000; want[5] = 1'b0;
        settle_and_clear();
        for (int i = 0; i < 6; i++) begin
            ex_rmem = vec[i][8]; ex_wreg = vec[i][7];
            id_uses_r2 = vec[i][6]; id_uses_r3 = vec[i][5];
            ex_dest = 4'd9;
            id_r2 = vec[i][4] ? 4'd9 : 4'd3;
            id_r3 = vec[i][3] ? 4'd9 : 4'd4;
            @(negedge clk);
            checks++;
            if (a_pc !== want[i]) begin
                failures++; $display("FAIL hz_decode_%0d pc_hold=%b want=%b", i, a_pc, want[i]);
            end
            next_cycle();
        end
        // register 0 is an ordinary register
        ex_rmem = 1'b1; ex_wreg = 1'b1; ex_dest = 4'd0; id_r2 = 4'd7; id_r3 = 4'd0;
        id_uses_r2 = 1'b1; id_uses_r3 = 1'b1;
        @(negedge clk);
        checks++;
        if (a_pc !== 1'b1) begin
            failures++; $display("FAIL hz_reg0 pc_hold=%b want=1", a_pc);
        end
        next_cycle();
        zero_inputs();
    endtask

    task automatic test_load_use_n1();
        settle_and_clear();
        load_use_vec();
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifh, a_idb, a_iff, a_idh} !== 5'b11100) begin
            failures++; $display("FAIL ld_n1_stall pc/ifh/idb/iff/idh=%b want=11100", {a_pc, a_ifh, a_idb, a_iff, a_idh});
        end
        next_cycle();
        zero_inputs();
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifh, a_idb} !== 3'b000 || a_st !== 2'd0 || a_sc !== 16'd1) begin
            failures++; $display("FAIL ld_n1_after ctl=%b state=%0d stall=%0d want 000/0/1", {a_pc, a_ifh, a_idb}, a_st, a_sc);
        end
        next_cycle();
    endtask

    task automatic test_load_use_n3();
        logic [1:0] exp_st [4];
        logic       exp_pc [4];
        exp_st[0] = 2'd0; exp_st[1] = 2'd1; exp_st[2] = 2'd1; exp_st[3] = 2'd0;
        exp_pc[0] = 1'b1; exp_pc[1] = 1'b1; exp_pc[2] = 1'b1; exp_pc[3] = 1'b0;
        settle_and_clear();
        load_use_vec();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b_pc !== exp_pc[i] || b_st !== exp_st[i]) begin
                failures++; $display("FAIL ld_n3_cyc%0d pc_hold=%b state=%0d want %b/%0d", i, b_pc, b_st, exp_pc[i], exp_st[i]);
            end
            next_cycle();
            if (i == 0) zero_inputs();
        end
        checks++;
        if (b_sc !== 16'd3) begin
            failures++; $display("FAIL ld_n3_count stall=%0d want=3", b_sc);
        end
    endtask

    task automatic test_jump();
        settle_and_clear();
        load_use_vec();
        jump_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_iff, a_idb, a_pc, a_ifh} !== 4'b1100) begin
            failures++; $display("FAIL jump_ctl iff/idb/pc/ifh=%b want=1100", {a_iff, a_idb, a_pc, a_ifh});
        end
        next_cycle();
        zero_inputs();
        checks++;
        if (a_fc !== 16'd1 || a_sc !== 16'd0 || a_st !== 2'd0) begin
            failures++; $display("FAIL jump_cnt flush=%0d stall=%0d state=%0d want 1/0/0", a_fc, a_sc, a_st);
        end
    endtask

    task automatic test_jump_in_ldstall();
        settle_and_clear();
        load_use_vec();
        next_cycle();
        zero_inputs();
        jump_en = 1'b1;
        @(negedge clk);
        checks++;
        if (b_st !== 2'd1 || {b_pc, b_iff, b_idb} !== 3'b011) begin
            failures++; $display("FAIL ldstall_jump state=%0d pc/iff/idb=%b want 1/011", b_st, {b_pc, b_iff, b_idb});
        end
        next_cycle();
        zero_inputs();
        checks++;
        if (b_st !== 2'd0 || b_fc !== 16'd1 || b_sc !== 16'd1) begin
            failures++; $display("FAIL ldstall_jump_after state=%0d flush=%0d stall=%0d want 0/1/1", b_st, b_fc, b_sc);
        end
    endtask

    task automatic test_memwait_mid_stall();
        // cycle 0 detect, 1-4 busy, 5 wait-exit in LDSTALL rules, 6 last LDSTALL, 7 idle
        logic [1:0] exp_st [8];
        logic [1:0] exp_ctl [8];   // {pc_hold, memwb_bubble}
        exp_st[0] = 2'd0; exp_st[1] = 2'd1; exp_st[2] = 2'd2; exp_st[3] = 2'd2;
        exp_st[4] = 2'd2; exp_st[5] = 2'd2; exp_st[6] = 2'd1; exp_st[7] = 2'd0;
        exp_ctl[0] = 2'b10; exp_ctl[1] = 2'b11; exp_ctl[2] = 2'b11; exp_ctl[3] = 2'b11;
        exp_ctl[4] = 2'b11; exp_ctl[5] = 2'b10; exp_ctl[6] = 2'b10; exp_ctl[7] = 2'b00;
        settle_and_clear();
        load_use_vec();
        for (int i = 0; i < 8; i++) begin
            if (i >= 1) begin
                zero_inputs();
                mem_busy = (i <= 4);
            end
            @(negedge clk);
            checks++;
            if ({b_pc, b_mwb} !== exp_ctl[i] || b_st !== exp_st[i] ||
                (i >= 1 && i <= 4 && {b_ifh, b_idh, b_exh} !== 3'b111)) begin
                failures++; $display("FAIL memwait_cyc%0d pc/mwb=%b state=%0d holds=%b want %b/%0d", i, {b_pc, b_mwb}, b_st, {b_ifh, b_idh, b_exh}, exp_ctl[i], exp_st[i]);
            end
            next_cycle();
        end
        zero_inputs();
        checks++;
        if (b_sc !== 16'd7) begin
            failures++; $display("FAIL memwait_count stall=%0d want=7", b_sc);
        end
    endtask

    task automatic test_reset_mid_stall();
        settle_and_clear();
        load_use_vec();
        next_cycle();
        zero_inputs();
        next_cycle();
        checks++;
        if (b_st !== 2'd1 || b_sc !== 16'd2) begin
            failures++; $display("FAIL pre_reset state=%0d stall=%0d want 1/2", b_st, b_sc);
        end
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (b_st !== 2'd0 || b_sc !== 16'd0 || b_fc !== 16'd0 ||
            {b_pc, b_ifh, b_iff, b_idh, b_idb, b_exh, b_mwb} !== 7'b0) begin
            failures++; $display("FAIL reset_mid state=%0d stall=%0d flush=%0d outs=%b want 0/0/0/0", b_st, b_sc, b_fc, {b_pc, b_ifh, b_iff, b_idh, b_idb, b_exh, b_mwb});
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        settle_and_clear();
        mem_busy = 1'b1;
        repeat (20) next_cycle();
        checks++;
        if (c_sc !== 4'd15 || c_st !== 2'd2) begin
            failures++; $display("FAIL sat_hold stall=%0d state=%0d want 15/2", c_sc, c_st);
        end
        clr_cnt = 1'b1;
        next_cycle();
        clr_cnt = 1'b0;
        checks++;
        if (c_sc !== 4'd0) begin
            failures++; $display("FAIL sat_clear stall=%0d want=0", c_sc);
        end
        next_cycle();
        checks++;
        if (c_sc !== 4'd1) begin
            failures++; $display("FAIL sat_after_clear stall=%0d want=1", c_sc);
        end
        mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({c_pc, c_exh, c_mwb} !== 3'b000) begin
            failures++; $display("FAIL sat_release ctl=%b want=000", {c_pc, c_exh, c_mwb});
        end
        next_cycle();
        checks++;
        if (c_st !== 2'd0 || c_sc !== 4'd1) begin
            failures++; $display("FAIL sat_release_regs state=%0d stall=%0d want 0/1", c_st, c_sc);
        end
    endtask

    initial begin
        rst = 1'b0;
        zero_inputs();
        test_reset();
        test_hazard_decode();
        test_load_use_n1();
        test_load_use_n3();
        test_jump();
        test_jump_in_ldstall();
        test_memwait_mid_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
